// File: rtl/core_pkg.sv
// Shared types and helpers for the ioctl-to-SDRAM download path.
package core_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, FLUSH} loader_state_t;

  localparam int LOADER_REGION_SHIFT = 20;

  // Low lanes*lbytes bits set; covers SDRAM words up to 8 bytes wide.
  function automatic logic [7:0] be_mask(input int unsigned lanes, input int unsigned lbytes);
    logic [7:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (i < lanes * lbytes) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs consecutive ioctl words little-endian into one SDRAM-width word.
module word_packer
  import core_pkg::*;
#(
  parameter int IOCTL_W = 16,
  parameter int DATA_W  = 32,
  parameter int LANE_W  = $clog2(DATA_W / IOCTL_W + 1)
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                restart,
  input  logic                store,
  input  logic                clear,
  input  logic [IOCTL_W-1:0]  din,
  output logic [DATA_W-1:0]   data,
  output logic [LANE_W-1:0]   lane,
  output logic                last,
  output logic [DATA_W/8-1:0] be_part
);

  localparam int WORDS  = DATA_W / IOCTL_W;
  localparam int BPW    = DATA_W / 8;
  localparam int LBYTES = IOCTL_W / 8;

  assign last = (lane == LANE_W'(WORDS - 1));

  // Enables for the lanes filled so far, used when a partial word is flushed.
  always_comb begin
    be_part = BPW'(be_mask(32'(lane), LBYTES));
  end

  always_ff @(posedge clk_sys) begin
    if (reset || restart) begin
      data <= '0;
      lane <= '0;
    end else if (store) begin
      for (int i = 0; i < WORDS; i++)
        if (lane == LANE_W'(i)) data[i*IOCTL_W +: IOCTL_W] <= din;
      lane <= last ? '0 : lane + 1'b1;
    end else if (clear) begin
      data <= '0;
    end
  end

endmodule

// File: rtl/ioctl_sdram_loader.sv
// Host download engine: packs ioctl words and writes them to per-index SDRAM
// regions over the toggle req/ack write port.
module ioctl_sdram_loader
  import core_pkg::*;
#(
  parameter int IOCTL_W      = 16,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 25,
  parameter int NUM_IDX      = 2,
  parameter int REGION_SHIFT = LOADER_REGION_SHIFT
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [IOCTL_W-1:0]  ioctl_dout,
  output logic                ioctl_wait,
  output logic [ADDR_W-1:0]   sdram_waddr,
  output logic [DATA_W-1:0]   sdram_din,
  output logic [DATA_W/8-1:0] sdram_be,
  output logic                sdram_we_req,
  input  logic                sdram_we_ack,
  output logic                active,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [ADDR_W-1:0]   byte_count
);

  localparam int WORDS  = DATA_W / IOCTL_W;
  localparam int BPW    = DATA_W / 8;
  localparam int LBYTES = IOCTL_W / 8;
  localparam int LANE_W = $clog2(WORDS + 1);

  loader_state_t     state, state_d;
  logic              dl_ok, dl_ok_q, rise, fall, ack_ok, pending_end;
  logic              start, store, go_write, go_flush, wr_done, flush_done, finish;
  logic [LANE_W-1:0] lane;
  logic              last;
  logic [BPW-1:0]    be_part;
  logic              unused_idx_hi;

  assign unused_idx_hi = ^ioctl_index[7:6];
  assign dl_ok  = ioctl_download & (int'(ioctl_index[5:0]) < NUM_IDX);
  assign rise   = dl_ok & ~dl_ok_q;
  assign fall   = dl_ok_q & ~dl_ok;
  assign ack_ok = (sdram_we_ack == sdram_we_req);

  word_packer #(.IOCTL_W(IOCTL_W), .DATA_W(DATA_W), .LANE_W(LANE_W)) u_packer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .restart (start),
    .store   (store),
    .clear   (wr_done),
    .din     (ioctl_dout),
    .data    (sdram_din),
    .lane    (lane),
    .last    (last),
    .be_part (be_part)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // A strobe coinciding with the end of download is stored first; the end is
  // remembered in pending_end and handled on a later FILL cycle.
  always_comb begin
    state_d    = state;
    start      = 1'b0;
    store      = 1'b0;
    go_write   = 1'b0;
    go_flush   = 1'b0;
    wr_done    = 1'b0;
    flush_done = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_d = FILL;
        start   = 1'b1;
      end
      FILL: if (ioctl_wr) begin
        store = 1'b1;
        if (last) begin
          state_d  = WRITE;
          go_write = 1'b1;
        end
      end else if (fall || pending_end) begin
        if (lane == '0) begin
          state_d = IDLE;
          finish  = 1'b1;
        end else begin
          state_d  = FLUSH;
          go_flush = 1'b1;
        end
      end
      WRITE: if (ack_ok) begin
        state_d = FILL;
        wr_done = 1'b1;
      end
      FLUSH: if (ack_ok) begin
        state_d    = IDLE;
        flush_done = 1'b1;
        finish     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ioctl_wait = (state == WRITE);
    busy       = (state == WRITE) || (state == FLUSH);
    active     = (state != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_ok_q     <= 1'b0;
      pending_end <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      byte_count  <= '0;
      sdram_be    <= '0;
    end else begin
      dl_ok_q <= dl_ok;
      done    <= finish;
      if (start) begin
        overrun     <= 1'b0;
        byte_count  <= '0;
        pending_end <= 1'b0;
      end else begin
        if (ioctl_wr && ioctl_wait) overrun <= 1'b1;
        if (finish)
          pending_end <= 1'b0;
        else if (fall && (state == FILL || state == WRITE))
          pending_end <= 1'b1;
        if (wr_done)
          byte_count <= byte_count + ADDR_W'(BPW);
        else if (flush_done)
          byte_count <= byte_count + ADDR_W'(lane) * ADDR_W'(LBYTES);
      end
      if (go_write)      sdram_be <= '1;
      else if (go_flush) sdram_be <= be_part;
    end
  end

  // The request toggle survives reset so a late ack from an abandoned write
  // merely brings ack back in line with req.
  always_ff @(posedge clk_sys) begin
    if (!reset && (go_write || go_flush)) sdram_we_req <= ~sdram_we_req;
    if (!reset && start)
      sdram_waddr <= ADDR_W'(64'(ioctl_index[5:0]) << REGION_SHIFT);
    else if (!reset && wr_done)
      sdram_waddr <= sdram_waddr + ADDR_W'(BPW);
  end

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Scoreboard bench for ioctl_sdram_loader: a 16->32 instance and an 8->64 instance.
module tb_ioctl_sdram_loader;

  typedef struct packed {
    logic [24:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } wr_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  int vectors = 0;
  int fails   = 0;

  // 16 -> 32 instance
  logic        dl_a = 0, wr_a = 0, ack_a = 0;
  logic [7:0]  idx_a = 0;
  logic [15:0] dout_a = 0;
  logic        wait_a, req_a, active_a, busy_a, done_a, overrun_a;
  logic [24:0] waddr_a, bc_a;
  logic [31:0] din_a;
  logic [3:0]  be_a;

  // 8 -> 64 instance
  logic        dl_b = 0, wr_b = 0, ack_b = 0;
  logic [7:0]  idx_b = 0;
  logic [7:0]  dout_b = 0;
  logic        wait_b, req_b, active_b, busy_b, done_b, overrun_b;
  logic [24:0] waddr_b, bc_b;
  logic [63:0] din_b;
  logic [7:0]  be_b;

  ioctl_sdram_loader dut_a (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl_a), .ioctl_index(idx_a),
    .ioctl_wr(wr_a), .ioctl_dout(dout_a), .ioctl_wait(wait_a), .sdram_waddr(waddr_a),
    .sdram_din(din_a), .sdram_be(be_a), .sdram_we_req(req_a), .sdram_we_ack(ack_a),
    .active(active_a), .busy(busy_a), .done(done_a), .overrun(overrun_a), .byte_count(bc_a)
  );

  ioctl_sdram_loader #(.IOCTL_W(8), .DATA_W(64)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl_b), .ioctl_index(idx_b),
    .ioctl_wr(wr_b), .ioctl_dout(dout_b), .ioctl_wait(wait_b), .sdram_waddr(waddr_b),
    .sdram_din(din_b), .sdram_be(be_b), .sdram_we_req(req_b), .sdram_we_ack(ack_b),
    .active(active_b), .busy(busy_b), .done(done_b), .overrun(overrun_b), .byte_count(bc_b)
  );

  wr_t  qa[$], qb[$];
  wr_t  ea, eb;
  int   ack_dly_a = 2, ack_dly_b = 2, cnt_a = 0, cnt_b = 0;
  int   done_cnt_a = 0, done_cnt_b = 0;
  logic seen_a = 0, seen_b = 0;
  bit   armed = 0;

  // SDRAM model + scoreboard for instance A
  always @(negedge clk_sys) begin
    if (!armed) begin
      seen_a = req_a; ack_a = req_a; cnt_a = 0;
    end else begin
      if (done_a) done_cnt_a++;
      if (req_a !== seen_a) begin
        seen_a = req_a;
        vectors++;
        if (qa.size() == 0) begin
          fails++;
          $display("FAIL wr_a_unexpected: got addr=%h din=%h be=%h, required no write", waddr_a, din_a, be_a);
        end else begin
          ea = qa.pop_front();
          if (ea !== {waddr_a, 64'(din_a), 8'(be_a)}) begin
            fails++;
            $display("FAIL wr_a: got addr=%h din=%h be=%h, required addr=%h din=%h be=%h",
                     waddr_a, din_a, be_a, ea.a, ea.d, ea.be);
          end
        end
      end
      if (ack_a !== req_a) begin
        if (cnt_a >= ack_dly_a) begin ack_a = req_a; cnt_a = 0; end
        else cnt_a++;
      end
    end
  end

  // SDRAM model + scoreboard for instance B
  always @(negedge clk_sys) begin
    if (!armed) begin
      seen_b = req_b; ack_b = req_b; cnt_b = 0;
    end else begin
      if (done_b) done_cnt_b++;
      if (req_b !== seen_b) begin
        seen_b = req_b;
        vectors++;
        if (qb.size() == 0) begin
          fails++;
          $display("FAIL wr_b_unexpected: got addr=%h din=%h be=%h, required no write", waddr_b, din_b, be_b);
        end else begin
          eb = qb.pop_front();
          if (eb !== {waddr_b, din_b, be_b}) begin
            fails++;
            $display("FAIL wr_b: got addr=%h din=%h be=%h, required addr=%h din=%h be=%h",
                     waddr_b, din_b, be_b, eb.a, eb.d, eb.be);
          end
        end
      end
      if (ack_b !== req_b) begin
        if (cnt_b >= ack_dly_b) begin ack_b = req_b; cnt_b = 0; end
        else cnt_b++;
      end
    end
  end

  task automatic host_wr_a(input logic [15:0] d, input bit drop);
    int n = 0;
    while (wait_a === 1'b1 && n < 200) begin @(negedge clk_sys); n++; end
    if (n >= 200) begin
      vectors++; fails++;
      $display("FAIL host_wr_a_wait: ioctl_wait=1 after 200 cycles, required 0");
    end
    wr_a = 1'b1; dout_a = d;
    if (drop) dl_a = 1'b0;
    @(negedge clk_sys);
    wr_a = 1'b0;
  endtask

  task automatic host_wr_b(input logic [7:0] d, input bit drop);
    int n = 0;
    while (wait_b === 1'b1 && n < 200) begin @(negedge clk_sys); n++; end
    if (n >= 200) begin
      vectors++; fails++;
      $display("FAIL host_wr_b_wait: ioctl_wait=1 after 200 cycles, required 0");
    end
    wr_b = 1'b1; dout_b = d;
    if (drop) dl_b = 1'b0;
    @(negedge clk_sys);
    wr_b = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (active_a === 1'b1 && n < 300) begin @(negedge clk_sys); n++; end
    if (n >= 300) begin
      vectors++; fails++;
      $display("FAIL idle_a: active=1 after 300 cycles, required 0");
    end
    @(negedge clk_sys);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (active_b === 1'b1 && n < 300) begin @(negedge clk_sys); n++; end
    if (n >= 300) begin
      vectors++; fails++;
      $display("FAIL idle_b: active=1 after 300 cycles, required 0");
    end
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    armed = 1'b1;
    @(negedge clk_sys);
    vectors++; if (wait_a !== 1'b0)    begin fails++; $display("FAIL rst_wait: got %b, required 0", wait_a); end
    vectors++; if (active_a !== 1'b0)  begin fails++; $display("FAIL rst_active: got %b, required 0", active_a); end
    vectors++; if (busy_a !== 1'b0)    begin fails++; $display("FAIL rst_busy: got %b, required 0", busy_a); end
    vectors++; if (done_a !== 1'b0)    begin fails++; $display("FAIL rst_done: got %b, required 0", done_a); end
    vectors++; if (overrun_a !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b, required 0", overrun_a); end
    vectors++; if (bc_a !== 25'd0)     begin fails++; $display("FAIL rst_byte_count: got %0d, required 0", bc_a); end
    vectors++; if (din_a !== 32'd0)    begin fails++; $display("FAIL rst_din: got %h, required 0", din_a); end
    vectors++; if (be_a !== 4'd0)      begin fails++; $display("FAIL rst_be: got %h, required 0", be_a); end
    vectors++; if (active_b !== 1'b0)  begin fails++; $display("FAIL rst_active_b: got %b, required 0", active_b); end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_full_words();
    int d0 = done_cnt_a;
    qa.push_back('{a: 25'h000000, d: 64'h22221111, be: 8'hF});
    qa.push_back('{a: 25'h000004, d: 64'h44443333, be: 8'hF});
    idx_a = 8'd0; dl_a = 1'b1;
    @(negedge clk_sys);
    vectors++; if (active_a !== 1'b1) begin fails++; $display("FAIL t1_active: got %b, required 1", active_a); end
    host_wr_a(16'h1111, 0);
    host_wr_a(16'h2222, 0);
    vectors++; if (wait_a !== 1'b1) begin fails++; $display("FAIL t1_wait_in_write: got %b, required 1", wait_a); end
    vectors++; if (busy_a !== 1'b1) begin fails++; $display("FAIL t1_busy: got %b, required 1", busy_a); end
    host_wr_a(16'h3333, 0);
    host_wr_a(16'h4444, 0);
    dl_a = 1'b0;
    wait_idle_a();
    vectors++; if (bc_a !== 25'd8) begin fails++; $display("FAIL t1_byte_count: got %0d, required 8", bc_a); end
    vectors++; if (done_cnt_a - d0 !== 1) begin fails++; $display("FAIL t1_done_pulses: got %0d, required 1", done_cnt_a - d0); end
    vectors++; if (qa.size() !== 0) begin fails++; $display("FAIL t1_pending_writes: got %0d, required 0", qa.size()); end
  endtask

  task automatic test_flush();
    int d0 = done_cnt_a;
    qa.push_back('{a: 25'h100000, d: 64'hBBBBAAAA, be: 8'hF});
    qa.push_back('{a: 25'h100004, d: 64'h0000CCCC, be: 8'h3});
    idx_a = 8'd1; dl_a = 1'b1;
    @(negedge clk_sys);
    host_wr_a(16'hAAAA, 0);
    host_wr_a(16'hBBBB, 0);
    host_wr_a(16'hCCCC, 0);
    dl_a = 1'b0;
    wait_idle_a();
    vectors++; if (bc_a !== 25'd6) begin fails++; $display("FAIL t2_byte_count: got %0d, required 6", bc_a); end
    vectors++; if (done_cnt_a - d0 !== 1) begin fails++; $display("FAIL t2_done_pulses: got %0d, required 1", done_cnt_a - d0); end
    vectors++; if (qa.size() !== 0) begin fails++; $display("FAIL t2_pending_writes: got %0d, required 0", qa.size()); end
  endtask

  task automatic test_bad_index();
    int   d0 = done_cnt_a;
    logic r0 = req_a;
    idx_a = 8'd5; dl_a = 1'b1;
    repeat (3) @(negedge clk_sys);
    host_wr_a(16'h1234, 0);
    repeat (5) @(negedge clk_sys);
    vectors++; if (active_a !== 1'b0) begin fails++; $display("FAIL t3_active: got %b, required 0", active_a); end
    vectors++; if (wait_a !== 1'b0)   begin fails++; $display("FAIL t3_wait: got %b, required 0", wait_a); end
    vectors++; if (req_a !== r0)      begin fails++; $display("FAIL t3_req: got %b, required %b", req_a, r0); end
    vectors++; if (bc_a !== 25'd6)    begin fails++; $display("FAIL t3_byte_count_hold: got %0d, required 6", bc_a); end
    dl_a = 1'b0;
    repeat (3) @(negedge clk_sys);
    vectors++; if (done_cnt_a !== d0) begin fails++; $display("FAIL t3_done: got %0d pulses, required 0", done_cnt_a - d0); end
  endtask

  task automatic test_overrun();
    ack_dly_a = 20;
    qa.push_back('{a: 25'h000000, d: 64'h22221111, be: 8'hF});
    qa.push_back('{a: 25'h000004, d: 64'h00003333, be: 8'h3});
    idx_a = 8'd0; dl_a = 1'b1;
    @(negedge clk_sys);
    vectors++; if (overrun_a !== 1'b0) begin fails++; $display("FAIL t4_overrun_start: got %b, required 0", overrun_a); end
    host_wr_a(16'h1111, 0);
    host_wr_a(16'h2222, 0);
    repeat (2) @(negedge clk_sys);
    vectors++; if (wait_a !== 1'b1) begin fails++; $display("FAIL t4_wait: got %b, required 1", wait_a); end
    wr_a = 1'b1; dout_a = 16'h9999;
    @(negedge clk_sys);
    wr_a = 1'b0;
    @(negedge clk_sys);
    vectors++; if (overrun_a !== 1'b1) begin fails++; $display("FAIL t4_overrun: got %b, required 1", overrun_a); end
    vectors++; if (din_a !== 32'h22221111) begin fails++; $display("FAIL t4_din_kept: got %h, required 22221111", din_a); end
    host_wr_a(16'h3333, 1);
    wait_idle_a();
    vectors++; if (overrun_a !== 1'b1) begin fails++; $display("FAIL t4_overrun_sticky: got %b, required 1", overrun_a); end
    vectors++; if (bc_a !== 25'd6) begin fails++; $display("FAIL t4_byte_count: got %0d, required 6", bc_a); end
    vectors++; if (qa.size() !== 0) begin fails++; $display("FAIL t4_pending_writes: got %0d, required 0", qa.size()); end
    ack_dly_a = 2;
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    ack_dly_a = 30;
    qa.push_back('{a: 25'h000000, d: 64'h22221111, be: 8'hF});
    idx_a = 8'd0; dl_a = 1'b1;
    @(negedge clk_sys);
    host_wr_a(16'h1111, 0);
    host_wr_a(16'h2222, 0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b1; dl_a = 1'b0;
    @(negedge clk_sys);
    vectors++; if (wait_a !== 1'b0)   begin fails++; $display("FAIL t5_wait: got %b, required 0", wait_a); end
    vectors++; if (active_a !== 1'b0) begin fails++; $display("FAIL t5_active: got %b, required 0", active_a); end
    vectors++; if (busy_a !== 1'b0)   begin fails++; $display("FAIL t5_busy: got %b, required 0", busy_a); end
    vectors++; if (din_a !== 32'd0)   begin fails++; $display("FAIL t5_din: got %h, required 0", din_a); end
    reset = 1'b0;
    while (ack_a !== req_a && n < 100) begin @(negedge clk_sys); n++; end
    vectors++; if (n >= 100) begin fails++; $display("FAIL t5_late_ack: ack never matched req within 100 cycles"); end
    ack_dly_a = 2;
    qa.push_back('{a: 25'h000000, d: 64'h66665555, be: 8'hF});
    dl_a = 1'b1;
    @(negedge clk_sys);
    host_wr_a(16'h5555, 0);
    host_wr_a(16'h6666, 0);
    dl_a = 1'b0;
    wait_idle_a();
    vectors++; if (bc_a !== 25'd4) begin fails++; $display("FAIL t5_byte_count: got %0d, required 4", bc_a); end
    vectors++; if (qa.size() !== 0) begin fails++; $display("FAIL t5_pending_writes: got %0d, required 0", qa.size()); end
  endtask

  task automatic test_wide_bytes();
    int d0 = done_cnt_b;
    qb.push_back('{a: 25'h000000, d: 64'h0000000504030201, be: 8'h1F});
    idx_b = 8'd0; dl_b = 1'b1;
    @(negedge clk_sys);
    for (int i = 1; i <= 4; i++) host_wr_b(8'(i), 0);
    host_wr_b(8'h05, 1);
    wait_idle_b();
    vectors++; if (bc_b !== 25'd5) begin fails++; $display("FAIL t6_byte_count: got %0d, required 5", bc_b); end
    vectors++; if (done_cnt_b - d0 !== 1) begin fails++; $display("FAIL t6_done_pulses: got %0d, required 1", done_cnt_b - d0); end
    vectors++; if (qb.size() !== 0) begin fails++; $display("FAIL t6_pending_writes: got %0d, required 0", qb.size()); end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_flush();
    test_bad_index();
    test_overrun();
    test_reset_mid_write();
    test_wide_bytes();
    repeat (5) @(negedge clk_sys);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ioctl_sdram_loader.md
Name: ioctl_sdram_loader

Overview:
Parametrised host-download engine that replaces the fixed 2×16→32 ROM loader. It packs N ioctl words into one SDRAM-width word and places each ioctl_index region at its own SDRAM base. Writes go to the sdram controller over the toggle req/ack write port, and a partial final word is flushed with a reduced byte enable. It sits between the HPS ioctl bus and the sdram write-port mux in the core top level; the top level uses `active` as the mux select.

Parameters:
IOCTL_W, 16, ioctl data width in bits; must be 8 or 16.
DATA_W, 32, SDRAM write word width; must be a multiple of IOCTL_W, up to 64.
ADDR_W, 25, SDRAM byte address width.
NUM_IDX, 2, count of accepted indices; ioctl_index[5:0] < NUM_IDX is accepted.
REGION_SHIFT, 20, region base = ioctl_index[5:0] << REGION_SHIFT.

Ports:
clk_sys  in  1  sole clock
reset  in  1  synchronous, active-high
ioctl_download  in  1  download in progress
ioctl_index  in  8  download target index
ioctl_wr  in  1  one-cycle data strobe
ioctl_dout  in  IOCTL_W  download data
ioctl_wait  out  1  stall request to the host
sdram_waddr  out  ADDR_W  byte address of the packed word
sdram_din  out  DATA_W  packed write data
sdram_be  out  DATA_W/8  byte enables, active-high
sdram_we_req  out  1  toggle request
sdram_we_ack  in  1  toggle acknowledge; transaction complete when ack == req
active  out  1  loader owns the SDRAM write port
busy  out  1  a write is outstanding
done  out  1  one-cycle pulse when a download completes
overrun  out  1  sticky: ioctl_wr arrived while ioctl_wait=1
byte_count  out  ADDR_W  bytes committed in the current or last download

Behaviour:
- Clock and reset: single clock clk_sys. Reset is synchronous, active-high.
- Reset values: ioctl_wait=0, active=0, busy=0, done=0, overrun=0, byte_count=0, lane=0, sdram_din=0, sdram_be=0, state IDLE.
  - sdram_we_req keeps its value through reset, so a late ack from an abandoned write only makes ack==req and is harmless.
- Derived constants:
  - WORDS = DATA_W/IOCTL_W.
  - BPW = DATA_W/8 (bytes per SDRAM word).
  - LBYTES = IOCTL_W/8 (bytes per ioctl word).
- Accept condition: dl_ok = ioctl_download & (ioctl_index[5:0] < NUM_IDX).
  - Rising-edge detection uses a registered copy of dl_ok.
- States: IDLE, FILL, WRITE, FLUSH.
- IDLE:
  - Rising edge of dl_ok → FILL.
  - On entry: active=1, waddr = index<<REGION_SHIFT (truncated to ADDR_W), lane=0, byte_count=0, overrun=0.
- FILL, each ioctl_wr:
  - ioctl_dout is stored in lane `lane`. Lane 0 is the least-significant bits, so the first word received is the lowest address (little-endian).
  - If lane == WORDS-1: on the next edge set ioctl_wait=1, sdram_be = all ones, toggle sdram_we_req, lane=0, → WRITE. Otherwise lane+1.
- WRITE:
  - busy=1. Wait for ack == req.
  - Then: ioctl_wait=0, waddr += BPW, byte_count += BPW, lane data cleared to 0, → FILL.
  - Earliest next request is 1 cycle after the ack is seen.
- ioctl_wr while in WRITE (host violated wait): the word is dropped and overrun=1 (sticky).
- Falling edge of dl_ok in FILL:
  - lane==0 → done=1, active=0, → IDLE.
  - lane>0 → flush the partial word: sdram_be = low lane×LBYTES bits set, unfilled lanes =0, toggle req, → FLUSH.
- Falling edge of dl_ok in WRITE: the current write finishes first; the falling-edge handling above then applies on return to FILL (the edge is latched as pending_end).
- FLUSH:
  - On ack==req: byte_count += lane×LBYTES, done=1, active=0, → IDLE.
- active rule: active stays 1 from entry until the final ack, so the mux does not switch mid-transaction.
- Simultaneous events: ioctl_wr on the same cycle as the dl_ok falling edge is accepted first, then flushed.
- Address wrap: waddr wraps modulo 2^ADDR_W, with no error.
- Reset during WRITE or FLUSH: the outstanding write is abandoned; the host sees ioctl_wait drop on the next cycle.
- Unaccepted index: no effect; all outputs hold their idle values.

Decomposition:
- Shared package (core_pkg):
  - loader_state_t enum (IDLE, FILL, WRITE, FLUSH).
  - Function be_mask(lanes, lbytes).
  - Constant LOADER_REGION_SHIFT.
- Sub-module word_packer: lane register, lane counter, be generation, clear.
  - The FSM and the handshake stay in ioctl_sdram_loader.

Test Plan:
1. Defaults, index 0. Host writes 16'h1111, 2222, 3333, 4444 → two writes: waddr 0x000000 din 32'h22221111 be 4'hF, then waddr 0x000004 din 32'h44443333. byte_count=8, one done pulse.
2. Index 1, three words AAAA, BBBB, CCCC, then download drops → writes at 0x100000 (be F) and 0x100004 (din 32'h0000CCCC, be 4'h3). byte_count=6.
3. Index 5 (≥NUM_IDX) → active stays 0, no req toggle, ioctl_wait stays 0.
4. SDRAM ack delayed 20 cycles, host pulses ioctl_wr while ioctl_wait=1 → word dropped, overrun=1, stored data unchanged.
5. reset asserted 3 cycles after a req toggle, ack arrives later → ioctl_wait=0 one cycle after reset, state IDLE, no spurious write on the next download.
6. DATA_W=64, IOCTL_W=8, five bytes 01..05 then end → a single write of din 64'h0000000504030201 with be 8'h1F.
